// File: rtl/bus_switch_arbiter.sv
// -----------------------------------------------------------------------------
// bus_switch_arbiter
//
// Round-robin arbiter sharing one W-bit switch-gated bus among N requesters.
// Each requester's data passes through a switch stage enabled only by its
// grant bit, so at most one source reaches the bus and an idle bus reads zero.
// An owner may hold the bus for a burst with lock, bounded by MAX_HOLD cycles.
//
// Parameters
//   N         number of requesters (2..8)
//   W         bus data width
//   MAX_HOLD  maximum consecutive cycles one owner keeps a grant (>= 1)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req[N]     request, bit i = requester i wants the bus
//   lock[N]    with req[i], owner i asks to keep the grant next cycle
//   in_data    requester data, slice i = in_data[i*W +: W]
//   grant[N]   registered one-hot grant, all zero when idle
//   out[W]     bus value, slice of the granted requester, zero when idle
//   out_valid  high whenever any grant is active
//   preempt    registered pulse: the previous cycle ended in a forced release
// -----------------------------------------------------------------------------
module bus_switch_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   grant,
    output logic [W-1:0]   out,
    output logic           out_valid,
    output logic           preempt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MAX_HOLD) + 1;

    // Last tenure cycle: an owner at this count must release even if locked.
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    // Pointer starts at the last requester so requester 0 wins first.
    localparam logic [PW-1:0] PTR_RST   = PW'(N - 1);

    // The bus is either idle or owned; the owner is identified by grant itself,
    // so the state is decoded from the grant register rather than stored twice.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // -------------------------------------------------------------------------
    // State registers and their next values
    // -------------------------------------------------------------------------
    logic [PW-1:0] ptr;
    logic [HW-1:0] hold_cnt;

    logic [N-1:0]  grant_nxt;
    logic [PW-1:0] ptr_nxt;
    logic [HW-1:0] hold_nxt;
    logic          preempt_nxt;

    arb_state_t    state;

    assign state = (|grant) ? ST_OWNED : ST_IDLE;

    // -------------------------------------------------------------------------
    // Round-robin scan
    // Candidates are visited in order ptr+1, ptr+2, ... wrapping mod N. While a
    // grant is held ptr equals the owner index, so the owner is visited last
    // and is only regranted when nobody else is requesting.
    // -------------------------------------------------------------------------
    logic [PW-1:0] scan_order [N];
    logic          scan_found;
    logic [PW-1:0] scan_idx;

    always_comb begin
        for (int off = 1; off <= N; off++) begin
            scan_order[off-1] = PW'((int'(ptr) + off) % N);
        end
    end

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default before any
        // conditional logic; a path that skips an assignment would infer a latch.
        scan_found = 1'b0;
        scan_idx   = ptr;
        for (int k = 0; k < N; k++) begin
            if (!scan_found && req[scan_order[k]]) begin
                scan_found = 1'b1;
                scan_idx   = scan_order[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic owner_wants;  // current owner still requesting with lock set
    logic at_limit;     // current owner has used its whole tenure
    logic keep;

    always_comb begin
        // NOTE: combinational blocks use blocking assignments so later lines see
        // the values computed above them; only the state register uses <=.
        owner_wants = |(grant & req & lock);
        at_limit    = (hold_cnt >= HOLD_LAST);
        keep        = 1'b0;

        grant_nxt   = '0;
        ptr_nxt     = ptr;
        hold_nxt    = '0;
        preempt_nxt = 1'b0;

        case (state)
            ST_OWNED: begin
                keep = owner_wants && !at_limit;
                if (keep) begin
                    grant_nxt = grant;
                    hold_nxt  = hold_cnt + HW'(1);
                end else begin
                    // A locked owner stopped only by the tenure limit is a
                    // forced release, flagged even if it wins the rescan.
                    preempt_nxt = owner_wants && at_limit;
                    if (scan_found) begin
                        grant_nxt[scan_idx] = 1'b1;
                        ptr_nxt             = scan_idx;
                    end
                end
            end
            default: begin
                if (scan_found) begin
                    grant_nxt[scan_idx] = 1'b1;
                    ptr_nxt             = scan_idx;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= '0;
            ptr      <= PTR_RST;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            grant    <= grant_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            preempt  <= preempt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Switch-gated bus: each slice is ANDed with its grant bit and the results
    // are ORed, so a one-hot grant passes exactly one source and an idle bus
    // reads zero. Purely combinational from grant and in_data.
    // -------------------------------------------------------------------------
    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++) begin
            out = out | (in_data[i*W +: W] & {W{grant[i]}});
        end
    end

    assign out_valid = |grant;

endmodule

// File: tb/tb_bus_switch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_switch_arbiter
//
// Self-checking bench for bus_switch_arbiter with N=4, W=8, MAX_HOLD=4.
// A table of directed vectors with hand-derived expectations covers reset,
// round robin, single requester and lock timeout; hand-written sequences cover
// same-cycle data pass-through, a lone locker and reset mid-burst; a random
// phase compares every cycle against a behavioural model that tracks the owner
// as an integer and its tenure as a count of held cycles.
// -----------------------------------------------------------------------------
module tb_bus_switch_arbiter;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int MAX_HOLD = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   grant;
    logic [W-1:0]   out;
    logic           out_valid;
    logic           preempt;

    bus_switch_arbiter #(
        .N        (N),
        .W        (W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .in_data   (in_data),
        .grant     (grant),
        .out       (out),
        .out_valid (out_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index (-1 = idle), last owner, cycles held so far.
    int   m_owner;
    int   m_ptr;
    int   m_ten;
    logic m_pre;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_out;
        logic        exp_pre;
    } vec_t;

    vec_t tv [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock: the model consumes the inputs present at the edge,
    // then outputs are sampled 1 time unit after the edge.
    task automatic tick();
        int   n_owner;
        int   n_ptr;
        int   n_ten;
        logic n_pre;
        bit   wants;
        int   j;
        if (rst) begin
            n_owner = -1;
            n_ptr   = N - 1;
            n_ten   = 0;
            n_pre   = 1'b0;
        end else begin
            wants   = (m_owner >= 0) && req[m_owner] && lock[m_owner];
            n_ptr   = m_ptr;
            n_pre   = 1'b0;
            if (wants && m_ten < MAX_HOLD) begin
                n_owner = m_owner;
                n_ten   = m_ten + 1;
            end else begin
                n_pre   = wants;  // still wanted it, so tenure ran out
                n_owner = -1;
                n_ten   = 0;
                for (int off = 1; off <= N; off++) begin
                    j = (m_ptr + off) % N;
                    if (n_owner < 0 && req[j]) begin
                        n_owner = j;
                        n_ptr   = j;
                        n_ten   = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        m_owner = n_owner;
        m_ptr   = n_ptr;
        m_ten   = n_ten;
        m_pre   = n_pre;
    endtask

    task automatic compare_model(input int cyc);
        logic [N-1:0] eg;
        logic [W-1:0] eo;
        eg = '0;
        eo = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            eo          = in_data[m_owner*W +: W];
        end
        check($sformatf("rnd%0d.grant", cyc), 32'(grant), 32'(eg));
        check($sformatf("rnd%0d.out", cyc), 32'(out), 32'(eo));
        check($sformatf("rnd%0d.out_valid", cyc), 32'(out_valid), 32'(m_owner >= 0));
        check($sformatf("rnd%0d.preempt", cyc), 32'(preempt), 32'(m_pre));
        check($sformatf("rnd%0d.onehot", cyc), 32'($countones(grant) <= 1), 32'd1);
    endtask

    initial begin
        m_owner = -1;
        m_ptr   = N - 1;
        m_ten   = 0;
        m_pre   = 1'b0;
        rst     = 1'b1;
        req     = '0;
        lock    = '0;
        in_data = '0;

        //        rst   req      lock     data          grant    out    pre
        tv[0]  = '{1'b1, 4'b1111, 4'b0000, 32'h44332211, 4'b0000, 8'h00, 1'b0};
        tv[1]  = '{1'b1, 4'b1111, 4'b0000, 32'h44332211, 4'b0000, 8'h00, 1'b0};
        tv[2]  = '{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0001, 8'h11, 1'b0};
        tv[3]  = '{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0010, 8'h22, 1'b0};
        tv[4]  = '{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0100, 8'h33, 1'b0};
        tv[5]  = '{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b1000, 8'h44, 1'b0};
        tv[6]  = '{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0001, 8'h11, 1'b0};
        tv[7]  = '{1'b0, 4'b0010, 4'b0000, 32'h4433A511, 4'b0010, 8'hA5, 1'b0};
        tv[8]  = '{1'b0, 4'b0000, 4'b0000, 32'h4433A511, 4'b0000, 8'h00, 1'b0};
        tv[9]  = '{1'b0, 4'b0011, 4'b0001, 32'h44332211, 4'b0001, 8'h11, 1'b0};
        tv[10] = '{1'b0, 4'b0011, 4'b0001, 32'h44332211, 4'b0001, 8'h11, 1'b0};
        tv[11] = '{1'b0, 4'b0011, 4'b0001, 32'h44332222, 4'b0001, 8'h22, 1'b0};
        tv[12] = '{1'b0, 4'b0011, 4'b0001, 32'h44332222, 4'b0001, 8'h22, 1'b0};
        tv[13] = '{1'b0, 4'b0011, 4'b0001, 32'h44332222, 4'b0010, 8'h22, 1'b1};
        tv[14] = '{1'b0, 4'b0011, 4'b0001, 32'h44332222, 4'b0001, 8'h22, 1'b0};

        // Directed table: reset, round robin, single requester, lock timeout.
        for (int i = 0; i < 15; i++) begin
            rst     = tv[i].rst;
            req     = tv[i].req;
            lock    = tv[i].lock;
            in_data = tv[i].data;
            tick();
            check($sformatf("vec%0d.grant", i), 32'(grant), 32'(tv[i].exp_grant));
            check($sformatf("vec%0d.out", i), 32'(out), 32'(tv[i].exp_out));
            check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(|tv[i].exp_grant));
            check($sformatf("vec%0d.preempt", i), 32'(preempt), 32'(tv[i].exp_pre));
        end

        // Owner 0 holds the bus: a data change shows on out without a clock edge.
        in_data = 32'h44332299;
        #1;
        check("passthru.out", 32'(out), 32'h99);

        // Go idle.
        req  = '0;
        lock = '0;
        tick();
        check("idle.grant", 32'(grant), 32'h0);
        check("idle.out", 32'(out), 32'h0);

        // Lone locker: regranted each tenure, preempt on cycles 5, 9, 13.
        req  = 4'b0001;
        lock = 4'b0001;
        for (int c = 1; c <= 13; c++) begin
            tick();
            check($sformatf("lone%0d.grant", c), 32'(grant), 32'h1);
            check($sformatf("lone%0d.preempt", c), 32'(preempt),
                  32'(c == 5 || c == 9 || c == 13));
        end

        // Dropping req releases at once, and that is not a forced release.
        req = '0;
        tick();
        check("drop.grant", 32'(grant), 32'h0);
        check("drop.preempt", 32'(preempt), 32'h0);

        // Reset during the second held cycle of a burst by requester 2.
        req  = 4'b1100;
        lock = 4'b0100;
        tick();
        check("rstmid.first.grant", 32'(grant), 32'h4);
        tick();
        check("rstmid.held.grant", 32'(grant), 32'h4);
        rst = 1'b1;
        tick();
        check("rstmid.rst.grant", 32'(grant), 32'h0);
        check("rstmid.rst.out_valid", 32'(out_valid), 32'h0);
        check("rstmid.rst.preempt", 32'(preempt), 32'h0);
        rst = 1'b0;
        tick();
        check("rstmid.resume.grant", 32'(grant), 32'h4);

        // Random phase against the behavioural model. Lock usually mirrors req
        // so bursts frequently run into the tenure limit.
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst     = ($urandom_range(0, 49) == 0);
            req     = N'($urandom());
            lock    = ($urandom_range(0, 3) == 0) ? N'($urandom()) : req;
            in_data = (N*W)'($urandom());
            tick();
            compare_model(cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_switch_arbiter.md
# bus_switch_arbiter

Round-robin arbiter that shares one W-bit switch-gated bus among N requesters. Each requester drives its data through a switch stage that is enabled only by its grant bit, so at most one source reaches the bus and an idle bus reads zero. The block sits between the requester register files and the shared bus. A lock input lets an owner hold the bus for a burst, and a hold-limit counter bounds each burst.

## Interface
- N, 4: number of requesters (2..8).
- W, 8: bus data width.
- MAX_HOLD, 4: maximum consecutive cycles one owner may keep a grant (>=1).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request; bit i set = requester i wants the bus.
- lock  input  N  bit i set with req[i] = owner i asks to keep the grant next cycle.
- in_data  input  N*W  requester data; slice i = in_data[i*W +: W].
- grant  output  N  registered one-hot grant (all zero when idle).
- out  output  W  bus value; slice of the granted requester, 0 when no grant.
- out_valid  output  1  |grant.
- preempt  output  1  registered 1-cycle pulse; the previous cycle ended in a forced release.

## Operation
- State registers: grant[N], ptr (index of last owner, clog2(N) bits), hold_cnt (clog2(MAX_HOLD)+1 bits), preempt.
- Reset values: grant=0, ptr=N-1 (requester 0 has top priority), hold_cnt=0, preempt=0. Combinational outputs follow, so out=0 and out_valid=0.
- IDLE (grant==0): if req!=0, grant the first set req bit scanning ptr+1, ptr+2, … mod N. Set ptr to that index and hold_cnt=0. Otherwise stay idle.
- OWNED by k:
  - Keep: req[k] && lock[k] && hold_cnt < MAX_HOLD-1. Grant unchanged, hold_cnt+1.
  - Otherwise release and re-arbitrate in the same edge. Scan starts at k+1 and wraps, so k is considered last. k is regranted only when it is the sole requester. On a new grant, hold_cnt=0 and ptr=new index. If no req is set, the next state is IDLE.
  - Forced release: the keep condition failed only because hold_cnt == MAX_HOLD-1. preempt=1 on the next cycle, including when k is regranted. Every other cycle preempt=0.
- A requester that drops req while owning loses the grant at the next edge regardless of lock.
- lock[i] without req[i] is ignored. lock of a non-owner is ignored.
- out = in_data slice selected by grant (AND-OR of switch stages), purely combinational from grant and in_data. Data changes on the owner's slice appear on out in the same cycle.
- grant is never multi-hot. Any X-free input combination yields one-hot or zero.

## Timing
- Request-to-grant latency: 1 cycle (req sampled at edge t, grant visible after edge t).
- Release latency: 1 cycle after req or lock drops.
- Maximum continuous tenure: MAX_HOLD cycles. Worst-case wait for a requesting input: (N-1)*MAX_HOLD cycles.
- Back-to-back handover has no idle bubble; grant moves directly from k to j at one edge.
- rst mid-burst: at the next edge grant=0, hold_cnt=0, ptr=N-1, preempt=0. Arbitration resumes on the edge after rst falls.
- No combinational path from req/lock to grant; out depends combinationally on in_data only.

## Test plan
All scenarios use N=4, W=8, MAX_HOLD=4.
- Reset: hold rst 2 cycles with req=1111 → grant=0000, out=0x00, out_valid=0, preempt=0; first edge after release gives grant=0001.
- Single requester: req=0010, in_data slice1=0xA5 → next cycle grant=0010, out=0xA5, out_valid=1; drop req → grant=0000 and out=0x00 next cycle.
- Round robin: req=1111, lock=0000 held → grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, preempt stays 0.
- Lock and timeout: req=0011, lock=0001 → grant=0001 for exactly 4 cycles, then grant=0010 with preempt=1 for one cycle. Change slice0 mid-burst 0x11→0x22 → out follows in the same cycle.
- Lone locker: req=0001, lock=0001 for 12 cycles → grant stays 0001 throughout; preempt pulses on cycles 5, 9, 13 after the first grant.
- Reset mid-burst: req=1100, lock=0100, assert rst during the 2nd held cycle → grant=0000 next edge; after release, grant=0100 (scan from 0 with ptr=3).
